// File: rtl/digit_serial_adder.sv
// digit_serial_adder: WIDTH-bit add done one 4-bit digit per clock, LSB first,
// through a single ripple-carry slice with a registered inter-digit carry.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    operand handshake (operand1, operand2, Cin)
//   out_valid/out_ready  result handshake (Result, Cout)
//   busy                 high while an operation is in RUN or DONE
//   ovf                  signed overflow, only with DIGIT_SERIAL_ADDER_OVF_EN
//
// Optional feature macro: DIGIT_SERIAL_ADDER_OVF_EN
module digit_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Cout,
  output logic             busy
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_bad_width
    $error("digit_serial_adder: WIDTH must be a multiple of 4 and >= 4");
  end

  localparam int NDIG = WIDTH / 4;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             carry;
  logic [CW-1:0]    cnt;

  // 4-bit ripple slice fed from the bottom digit of the shift regs
  logic [3:0] sa;
  logic [3:0] sb;
  logic [3:0] sum4;
  logic       c1;
  logic       c2;
  logic       c3;
  logic       c4;

  assign sa = a_sr[3:0];
  assign sb = b_sr[3:0];

  assign sum4[0] = sa[0] ^ sb[0] ^ carry;
  assign c1      = (sa[0] & sb[0]) | (carry & (sa[0] ^ sb[0]));
  assign sum4[1] = sa[1] ^ sb[1] ^ c1;
  assign c2      = (sa[1] & sb[1]) | (c1 & (sa[1] ^ sb[1]));
  assign sum4[2] = sa[2] ^ sb[2] ^ c2;
  assign c3      = (sa[2] & sb[2]) | (c2 & (sa[2] ^ sb[2]));
  assign sum4[3] = sa[3] ^ sb[3] ^ c3;
  assign c4      = (sa[3] & sb[3]) | (c3 & (sa[3] ^ sb[3]));

  // Sum digits enter at the top; after NDIG shifts digit 0 sits at the bottom.
  logic [WIDTH-1:0] res_nxt;
  always_comb begin
    res_nxt = Result >> 4;
    res_nxt[WIDTH-1 -: 4] = sum4;
  end

  logic last;
  assign last = (cnt == LAST);

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      Result <= '0;
      Cout   <= 1'b0;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr  <= operand1;
            b_sr  <= operand2;
            carry <= Cin;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 4;
          b_sr   <= b_sr >> 4;
          carry  <= c4;
          cnt    <= cnt + CW'(1);
          Result <= res_nxt;
          if (last) begin
            Cout  <= c4;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
            // operands share a sign but the sum's sign differs
            ovf   <= (sa[3] ~^ sb[3]) & (sum4[3] ^ sa[3]);
`endif
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_digit_serial_adder.sv
// tb_digit_serial_adder: randomized and directed checks of digit_serial_adder
// against an arithmetic reference, at WIDTH=16 and WIDTH=4.
module tb_digit_serial_adder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] op1;
  logic [15:0] op2;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] res;
  logic        cout;
  logic        busy;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
  logic        ovf;
  logic        w4_ovf;
`endif

  logic        w4_in_valid;
  logic        w4_in_ready;
  logic [3:0]  w4_op1;
  logic [3:0]  w4_op2;
  logic        w4_cin;
  logic        w4_out_valid;
  logic        w4_out_ready;
  logic [3:0]  w4_res;
  logic        w4_cout;
  logic        w4_busy;

  int vectors;
  int miscompares;

  logic [15:0] got_res;
  logic        got_cout;
  logic        got_ovf;
  int          got_lat;

  digit_serial_adder #(.WIDTH(16)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .operand1(op1),
    .operand2(op2),
    .Cin(cin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Result(res),
    .Cout(cout),
    .busy(busy)
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    ,
    .ovf(ovf)
`endif
  );

  digit_serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(w4_in_valid),
    .in_ready(w4_in_ready),
    .operand1(w4_op1),
    .operand2(w4_op2),
    .Cin(w4_cin),
    .out_valid(w4_out_valid),
    .out_ready(w4_out_ready),
    .Result(w4_res),
    .Cout(w4_cout),
    .busy(w4_busy)
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    ,
    .ovf(w4_ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One full transaction on the 16-bit DUT; captures outputs at out_valid.
  task automatic run_op(input logic [15:0] x, input logic [15:0] y,
                        input logic c, input int stall);
    @(negedge clk);
    op1 = x; op2 = y; cin = c;
    in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    op1 = 16'($urandom); op2 = 16'($urandom); cin = 1'($urandom);
    got_lat = 0;
    while (!out_valid && got_lat < 50) begin
      @(negedge clk);
      got_lat++;
    end
    got_res  = res;
    got_cout = cout;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    got_ovf  = ovf;
`else
    got_ovf  = 1'b0;
`endif
    repeat (stall) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    in_valid = 0; out_ready = 0; op1 = 0; op2 = 0; cin = 0;
    w4_in_valid = 0; w4_out_ready = 0; w4_op1 = 0; w4_op2 = 0; w4_cin = 0;
    #3;
    vectors++;
    if ({out_valid, busy, cout, res} !== 19'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b/%b/%b/%h want 0/0/0/0000",
               out_valid, busy, cout, res);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ready: in_ready=%b busy=%b want 1/0", in_ready, busy);
    end
  endtask

  task automatic test_carry_chain;
    run_op(16'hFFFF, 16'h0001, 1'b0, 0);
    vectors++;
    if (got_res !== 16'h0000 || got_cout !== 1'b1) begin
      miscompares++;
      $display("FAIL carry_chain: got %b_%h want 1_0000", got_cout, got_res);
    end
    vectors++;
    if (got_lat !== 4) begin
      miscompares++;
      $display("FAIL carry_latency: got %0d want 4", got_lat);
    end
    @(negedge clk);
    vectors++;
    if (res !== 16'h0000 || cout !== 1'b1 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL idle_hold: got %b_%h rdy=%b want 1_0000 rdy=1",
               cout, res, in_ready);
    end
  endtask

  task automatic test_busy;
    int lat;
    @(negedge clk);
    op1 = 16'h1234; op2 = 16'h4321; cin = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      vectors++;
      if (busy !== 1'b1 || in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL busy_run: busy=%b in_ready=%b want 1/0", busy, in_ready);
      end
      @(negedge clk);
      lat++;
    end
    vectors++;
    if (busy !== 1'b1 || in_ready !== 1'b0 || lat !== 4) begin
      miscompares++;
      $display("FAIL busy_done: busy=%b rdy=%b lat=%0d want 1/0/4",
               busy, in_ready, lat);
    end
    vectors++;
    if (res !== 16'h5556 || cout !== 1'b0) begin
      miscompares++;
      $display("FAIL sum_1234_4321: got %b_%h want 0_5556", cout, res);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    vectors++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_after: busy=%b rdy=%b want 0/1", busy, in_ready);
    end
  endtask

  task automatic test_backpressure;
    int lat;
    run_op(16'hFFFF, 16'h0001, 1'b0, 0);
    @(negedge clk);
    op1 = 16'h8000; op2 = 16'h8001; cin = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    op1 = 16'h0F0F; op2 = 16'h1010; cin = 1'b0; in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          res !== 16'h0002 || cout !== 1'b1) begin
        miscompares++;
        $display("FAIL bp_hold: ov=%b rdy=%b got %b_%h want 1/0 1_0002",
                 out_valid, in_ready, cout, res);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_release: rdy=%b ov=%b want 1/0", in_ready, out_valid);
    end
    @(negedge clk);
    in_valid = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_accept: busy=%b want 1", busy);
    end
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    vectors++;
    if (res !== 16'h1F1F || cout !== 1'b0 || lat !== 4) begin
      miscompares++;
      $display("FAIL bp_next: got %b_%h lat=%0d want 0_1F1F lat=4",
               cout, res, lat);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_op;
    @(negedge clk);
    op1 = 16'hABCD; op2 = 16'h1111; cin = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({out_valid, busy, cout, res} !== 19'd0) begin
      miscompares++;
      $display("FAIL rst_mid: got %b/%b/%b/%h want 0/0/0/0000",
               out_valid, busy, cout, res);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid_ready: got %b want 1", in_ready);
    end
    repeat (6) begin
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL rst_mid_novalid: got %b want 0", out_valid);
      end
    end
    run_op(16'h00FF, 16'h0001, 1'b0, 0);
    vectors++;
    if (got_res !== 16'h0100 || got_cout !== 1'b0 || got_lat !== 4) begin
      miscompares++;
      $display("FAIL rst_mid_after: got %b_%h lat=%0d want 0_0100 lat=4",
               got_cout, got_res, got_lat);
    end
  endtask

  task automatic test_random;
    logic [15:0] x;
    logic [15:0] y;
    logic        c;
    logic [16:0] exp_sum;
    logic        exp_ovf;
    for (int i = 0; i < 40; i++) begin
      x = 16'($urandom);
      y = 16'($urandom);
      c = 1'($urandom);
      exp_sum = {1'b0, x} + {1'b0, y} + {16'd0, c};
      exp_ovf = (x[15] == y[15]) && (exp_sum[15] != x[15]);
      run_op(x, y, c, int'($urandom_range(0, 3)));
      vectors++;
      if ({got_cout, got_res} !== exp_sum || got_lat !== 4) begin
        miscompares++;
        $display("FAIL rand_%0d: %h+%h+%b got %b_%h lat=%0d want %b_%h lat=4",
                 i, x, y, c, got_cout, got_res, got_lat,
                 exp_sum[16], exp_sum[15:0]);
      end
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
      vectors++;
      if (got_ovf !== exp_ovf) begin
        miscompares++;
        $display("FAIL rand_ovf_%0d: got %b want %b", i, got_ovf, exp_ovf);
      end
`endif
    end
  endtask

`ifdef DIGIT_SERIAL_ADDER_OVF_EN
  task automatic test_ovf;
    run_op(16'h7FFF, 16'h0001, 1'b0, 0);
    vectors++;
    if (got_res !== 16'h8000 || got_cout !== 1'b0 || got_ovf !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_pos: got %b_%h ovf=%b want 0_8000 ovf=1",
               got_cout, got_res, got_ovf);
    end
    run_op(16'h8000, 16'h8000, 1'b0, 2);
    vectors++;
    if (got_res !== 16'h0000 || got_cout !== 1'b1 || got_ovf !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_neg: got %b_%h ovf=%b want 1_0000 ovf=1",
               got_cout, got_res, got_ovf);
    end
    run_op(16'h0001, 16'h0001, 1'b0, 0);
    vectors++;
    if (got_res !== 16'h0002 || got_ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_none: got %h ovf=%b want 0002 ovf=0",
               got_res, got_ovf);
    end
  endtask
`endif

  task automatic test_width4;
    logic [3:0] x;
    logic [3:0] y;
    logic       c;
    logic [4:0] exp_sum;
    int         lat;
    for (int i = 0; i < 10; i++) begin
      if (i == 0) begin
        x = 4'h9; y = 4'h8; c = 1'b1;
      end else begin
        x = 4'($urandom); y = 4'($urandom); c = 1'($urandom);
      end
      exp_sum = {1'b0, x} + {1'b0, y} + {4'd0, c};
      @(negedge clk);
      w4_op1 = x; w4_op2 = y; w4_cin = c; w4_in_valid = 1'b1;
      @(negedge clk);
      w4_in_valid = 1'b0;
      w4_op1 = 4'($urandom); w4_op2 = 4'($urandom);
      lat = 0;
      while (!w4_out_valid && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      vectors++;
      if ({w4_cout, w4_res} !== exp_sum || lat !== 1) begin
        miscompares++;
        $display("FAIL w4_%0d: %h+%h+%b got %b_%h lat=%0d want %b_%h lat=1",
                 i, x, y, c, w4_cout, w4_res, lat, exp_sum[4], exp_sum[3:0]);
      end
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
      vectors++;
      if (w4_ovf !== ((x[3] == y[3]) && (exp_sum[3] != x[3]))) begin
        miscompares++;
        $display("FAIL w4_ovf_%0d: got %b", i, w4_ovf);
      end
`endif
      w4_out_ready = 1'b1;
      @(negedge clk);
      w4_out_ready = 1'b0;
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_carry_chain();
    test_busy();
    test_backpressure();
    test_reset_mid_op();
    test_random();
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    test_ovf();
`endif
    test_width4();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
